// File: rtl/display_scan.sv
// Four-digit seven-segment scan driver: double-buffered frame intake,
// per-slot digit multiplexing with brightness PWM, per-digit blink and dead time.
module display_scan #(
  parameter int unsigned SCAN_DIV       = 27000,
  parameter int unsigned BLINK_FRAMES   = 128,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [3:0]  blink_mask,
  input  logic [2:0]  brightness,
  output logic [6:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_sync
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned PW = SW + 4;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] S_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);
  localparam logic [PW-1:0] S_SPAN  = PW'(SCAN_DIV - 1);
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  // Scan position and frame buffers
  logic [SW-1:0] s_q, s_d;
  logic [1:0]    d_q, d_d;
  logic [27:0]   active_q, active_d;
  logic [27:0]   pending_q, pending_d;
  logic          pending_full_q, pending_full_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  // Registered pin drivers
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          sync_q, sync_d;

  logic          slot_wrap;
  logic          boundary;
  logic          accept;

  logic [6:0]    digit_segs;
  logic [3:0]    digit_onehot;
  logic [PW-1:0] on_prod;
  logic [PW-1:0] on_raw;
  logic [PW-1:0] on_len;
  logic [PW-1:0] s_ext;
  logic          lit;

  assign frame_ready = !pending_full_q;
  assign seg         = seg_q;
  assign dig         = dig_q;
  assign frame_sync  = sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q            <= '0;
      d_q            <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      blink_cnt_q    <= '0;
      blink_off_q    <= 1'b0;
      seg_q          <= SEG_OFF;
      dig_q          <= DIG_OFF;
      sync_q         <= 1'b0;
    end else begin
      s_q            <= s_d;
      d_q            <= d_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_off_q    <= blink_off_d;
      seg_q          <= seg_d;
      dig_q          <= dig_d;
      sync_q         <= sync_d;
    end
  end

  always_comb begin
    slot_wrap      = (s_q == S_LAST);
    boundary       = slot_wrap && (d_q == 2'd3);
    accept         = frame_valid && !pending_full_q;

    s_d            = slot_wrap ? '0 : s_q + SW'(1);
    d_d            = slot_wrap ? d_q + 2'd1 : d_q;

    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    // On a boundary a full pending buffer always wins; ready is low so no accept can collide.
    if (boundary) begin
      if (pending_full_q) begin
        active_d       = pending_q;
        pending_full_d = 1'b0;
      end else if (accept) begin
        active_d       = frame_in;
      end
    end else if (accept) begin
      pending_d      = frame_in;
      pending_full_d = 1'b1;
    end

    blink_cnt_d    = blink_cnt_q;
    blink_off_d    = blink_off_q;
    if (boundary) begin
      if (blink_cnt_q == B_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = !blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    case (d_q)
      2'd0:    digit_segs = active_q[6:0];
      2'd1:    digit_segs = active_q[13:7];
      2'd2:    digit_segs = active_q[20:14];
      default: digit_segs = active_q[27:21];
    endcase
    digit_onehot = 4'b0001 << d_q;

    // Lit window is s = 1..on_len; s = 0 stays dark as inter-digit dead time.
    on_prod = (PW'(brightness) + PW'(1)) * S_SPAN;
    on_raw  = on_prod >> 3;
    on_len  = (on_raw == '0) ? PW'(1) : on_raw;
    s_ext   = PW'(s_q);
    lit     = (s_ext != '0) && (s_ext <= on_len) && !(blink_off_q && blink_mask[d_q]);

    seg_d   = SEG_OFF;
    dig_d   = DIG_OFF;
    if (lit) begin
      seg_d = SEG_ACTIVE_LOW ? ~digit_segs : digit_segs;
      dig_d = DIG_ACTIVE_LOW ? ~digit_onehot : digit_onehot;
    end
    sync_d  = (s_q == '0) && (d_q == 2'd0);
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_DIV=9, BLINK_FRAMES=2, active-low pins.
// Output at sample n (negedges after the reset edge) shows frame f, digit d, slot s where n = 36f + 9d + s + 1.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] frame_in = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [3:0]  blink_mask = 4'b0000;
  logic [2:0]  brightness = 3'd7;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        frame_sync;

  int tests_run = 0;
  int tests_failed = 0;
  int n = 0;

  localparam logic [27:0] F  = {7'd119, 7'd56, 7'd63, 7'd118};
  localparam logic [27:0] F1 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
  localparam logic [27:0] F2 = {7'h66, 7'h6D, 7'h7D, 7'h07};
  localparam logic [27:0] F3 = {7'h7F, 7'h6F, 7'h77, 7'h7C};

  display_scan #(
    .SCAN_DIV(9),
    .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_in(frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .blink_mask(blink_mask),
    .brightness(brightness),
    .seg(seg),
    .dig(dig),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic goto(input int t);
    while (n < t) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    frame_valid = 1'b1; frame_in = F;
    step();
    frame_valid = 1'b0;
    goto(38);
    frame_valid = 1'b1; frame_in = F1;
    step();
    frame_valid = 1'b0;
    tests_run++;
    if (seg !== 7'h09 || dig !== 4'b1110) begin
      tests_failed++;
      $display("FAIL pre_reset_display seg=%h dig=%b expected seg=09 dig=1110", seg, dig);
    end
    tests_run++;
    if (frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_reset_ready got=%b expected=0", frame_ready);
    end
    do_reset();
    tests_run++;
    if (seg !== 7'h7F || dig !== 4'hF || frame_ready !== 1'b1 || frame_sync !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state seg=%h dig=%h ready=%b sync=%b expected 7f f 1 0", seg, dig, frame_ready, frame_sync);
    end
    step();
    tests_run++;
    if (frame_sync !== 1'b1 || dig !== 4'hF) begin
      tests_failed++;
      $display("FAIL first_sync sync=%b dig=%h expected sync=1 dig=f", frame_sync, dig);
    end
    step();
    tests_run++;
    if (seg !== 7'h7F || dig !== 4'b1110) begin
      tests_failed++;
      $display("FAIL active_cleared seg=%h dig=%b expected seg=7f dig=1110", seg, dig);
    end
    for (int k = 3; k <= 73; k++) begin
      step();
      tests_run++;
      if (frame_sync !== ((k == 37) || (k == 73))) begin
        tests_failed++;
        $display("FAIL sync_period n=%0d got=%b expected=%b", k, frame_sync, (k == 37) || (k == 73));
      end
    end
  endtask

  task automatic test_display();
    do_reset();
    frame_valid = 1'b1; frame_in = F;
    step();
    frame_valid = 1'b0;
    tests_run++;
    if (frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL display_ready_low got=%b expected=0", frame_ready);
    end
    step();
    tests_run++;
    if (seg !== 7'h7F || dig !== 4'b1110) begin
      tests_failed++;
      $display("FAIL display_old_frame seg=%h dig=%b expected seg=7f dig=1110", seg, dig);
    end
    goto(37);
    tests_run++;
    if (seg !== 7'h7F || dig !== 4'hF || frame_sync !== 1'b1) begin
      tests_failed++;
      $display("FAIL display_dead_s0 seg=%h dig=%h sync=%b expected 7f f 1", seg, dig, frame_sync);
    end
    for (int s = 1; s <= 8; s++) begin
      step();
      tests_run++;
      if (seg !== 7'h09 || dig !== 4'b1110) begin
        tests_failed++;
        $display("FAIL display_d0 s=%0d seg=%h dig=%b expected seg=09 dig=1110", s, seg, dig);
      end
    end
    goto(47);
    tests_run++;
    if (seg !== 7'h40 || dig !== 4'b1101) begin
      tests_failed++;
      $display("FAIL display_d1 seg=%h dig=%b expected seg=40 dig=1101", seg, dig);
    end
    goto(56);
    tests_run++;
    if (seg !== 7'h47 || dig !== 4'b1011) begin
      tests_failed++;
      $display("FAIL display_d2 seg=%h dig=%b expected seg=47 dig=1011", seg, dig);
    end
    goto(64);
    tests_run++;
    if (seg !== 7'h7F || dig !== 4'hF) begin
      tests_failed++;
      $display("FAIL display_d3_dead seg=%h dig=%h expected 7f f", seg, dig);
    end
    for (int s = 1; s <= 8; s++) begin
      step();
      tests_run++;
      if (seg !== 7'h08 || dig !== 4'b0111) begin
        tests_failed++;
        $display("FAIL display_d3 s=%0d seg=%h dig=%b expected seg=08 dig=0111", s, seg, dig);
      end
    end
  endtask

  task automatic test_handshake();
    do_reset();
    goto(4);
    frame_valid = 1'b1; frame_in = F1;
    step();
    frame_in = F2;
    tests_run++;
    if (frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_ready_fall got=%b expected=0", frame_ready);
    end
    goto(35);
    tests_run++;
    if (frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_hold_before_boundary got=%b expected=0", frame_ready);
    end
    step();
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hs_ready_rise got=%b expected=1", frame_ready);
    end
    step();
    frame_valid = 1'b0;
    tests_run++;
    if (frame_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_f2_accept ready=%b expected=0", frame_ready);
    end
    step();
    tests_run++;
    if (seg !== 7'h40 || dig !== 4'b1110) begin
      tests_failed++;
      $display("FAIL hs_f1_shown seg=%h dig=%b expected seg=40 dig=1110", seg, dig);
    end
    goto(65);
    tests_run++;
    if (seg !== 7'h30 || dig !== 4'b0111) begin
      tests_failed++;
      $display("FAIL hs_f1_d3 seg=%h dig=%b expected seg=30 dig=0111", seg, dig);
    end
    goto(72);
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hs_f2_drain ready=%b expected=1", frame_ready);
    end
    goto(74);
    tests_run++;
    if (seg !== 7'h78 || dig !== 4'b1110) begin
      tests_failed++;
      $display("FAIL hs_f2_shown seg=%h dig=%b expected seg=78 dig=1110", seg, dig);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    goto(35);
    tests_run++;
    if (seg !== 7'h7F || dig !== 4'b0111 || frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass_pre seg=%h dig=%b ready=%b expected 7f 0111 1", seg, dig, frame_ready);
    end
    frame_valid = 1'b1; frame_in = F3;
    step();
    frame_valid = 1'b0;
    tests_run++;
    if (frame_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass_ready got=%b expected=1", frame_ready);
    end
    step();
    tests_run++;
    if (frame_sync !== 1'b1 || dig !== 4'hF) begin
      tests_failed++;
      $display("FAIL bypass_sync sync=%b dig=%h expected 1 f", frame_sync, dig);
    end
    step();
    tests_run++;
    if (seg !== 7'h03 || dig !== 4'b1110) begin
      tests_failed++;
      $display("FAIL bypass_shown seg=%h dig=%b expected seg=03 dig=1110", seg, dig);
    end
  endtask

  task automatic test_brightness();
    brightness = 3'd0;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      goto(k);
      tests_run++;
      if (dig !== ((k == 2) ? 4'b1110 : 4'hF)) begin
        tests_failed++;
        $display("FAIL bright0 s=%0d dig=%b expected=%b", k - 1, dig, (k == 2) ? 4'b1110 : 4'hF);
      end
    end
    brightness = 3'd3;
    do_reset();
    for (int k = 19; k <= 27; k++) begin
      goto(k);
      tests_run++;
      if (dig !== ((k >= 20 && k <= 23) ? 4'b1011 : 4'hF)) begin
        tests_failed++;
        $display("FAIL bright3 s=%0d dig=%b expected=%b", k - 19, dig, (k >= 20 && k <= 23) ? 4'b1011 : 4'hF);
      end
    end
    brightness = 3'd7;
  endtask

  task automatic test_blink();
    logic [3:0] exp_dig0 [6];
    logic [6:0] exp_seg0 [6];
    logic [6:0] exp_seg1 [6];
    exp_dig0 = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hE, 4'hE};
    exp_seg0 = '{7'h7F, 7'h09, 7'h7F, 7'h7F, 7'h09, 7'h09};
    exp_seg1 = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    blink_mask = 4'b0001;
    do_reset();
    frame_valid = 1'b1; frame_in = F;
    step();
    frame_valid = 1'b0;
    for (int f = 0; f < 6; f++) begin
      goto(36 * f + 2);
      tests_run++;
      if (dig !== exp_dig0[f] || seg !== exp_seg0[f]) begin
        tests_failed++;
        $display("FAIL blink_d0 frame=%0d dig=%h seg=%h expected dig=%h seg=%h", f, dig, seg, exp_dig0[f], exp_seg0[f]);
      end
      goto(36 * f + 11);
      tests_run++;
      if (dig !== 4'b1101 || seg !== exp_seg1[f]) begin
        tests_failed++;
        $display("FAIL blink_d1 frame=%0d dig=%b seg=%h expected dig=1101 seg=%h", f, dig, seg, exp_seg1[f]);
      end
    end
    blink_mask = 4'b0000;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_display();
    test_handshake();
    test_bypass();
    test_brightness();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed driver for the four-digit seven-segment display. It is the consumer end of the 28-bit display frame that the menu and game blocks produce. It accepts a frame through a valid/ready handshake and double-buffers it so the frame changes only on a scan boundary, with no tearing. It scans one digit per slot, applies per-digit blink and global brightness, and drives the segment and digit-select pins.

## Interface
- `SCAN_DIV`, 27000 — clk cycles per digit slot; minimum 9.
- `BLINK_FRAMES`, 128 — full scan frames per blink phase; minimum 1.
- `SEG_ACTIVE_LOW`, 1 — 1: segment pins are lit at 0.
- `DIG_ACTIVE_LOW`, 1 — 1: digit selects are enabled at 0.
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `frame_in` in 28 — digit0=[6:0], digit1=[13:7], digit2=[20:14], digit3=[27:21]; bit0=seg a … bit6=seg g; 1=lit.
- `frame_valid` in 1 — `frame_in` is offered.
- `frame_ready` out 1 — pending buffer is empty; a transfer occurs when valid&&ready.
- `blink_mask` in 4 — bit n=1: digit n is blanked during the blink-off phase.
- `brightness` in 3 — 0 is dimmest, 7 is full.
- `seg` out 7 — segment pins, polarity per `SEG_ACTIVE_LOW`.
- `dig` out 4 — digit selects, bit n = digit n, polarity per `DIG_ACTIVE_LOW`.
- `frame_sync` out 1 — one-cycle pulse marking the start of a scan frame.

## Operation
- Slot counter `s` runs 0..`SCAN_DIV`-1. When `s` wraps, digit index `d` (0..3) increments.
- A frame boundary is the cycle where `s`=`SCAN_DIV`-1 and `d`=3.
- Buffers:
  - `active` is the frame being displayed; it resets to 0.
  - `pending` holds one frame plus a full flag.
  - `frame_ready` = !pending_full.
  - An accept outside a boundary cycle loads `pending` and sets full.
- Boundary cycle rules:
  - If pending is full: `active`<=`pending` and full clears. No accept is possible, because ready is low.
  - If pending is empty and an accept occurs in the same cycle: bypass, `active`<=`frame_in`, and pending stays empty.
  - If pending is empty and there is no accept: `active` is held.
- Brightness:
  - on_len = max(1, ((brightness+1)·(`SCAN_DIV`-1))>>3). Intermediate width is clog2(`SCAN_DIV`)+4 bits.
  - The digit is lit when 1 ≤ s ≤ on_len.
  - s=0 is always dead time, for anti-ghosting.
- Blink:
  - The frame counter counts boundaries 0..`BLINK_FRAMES`-1. On wrap, `blink_off` toggles.
  - Reset value of `blink_off` is 0 (visible).
  - When `blink_off` and blink_mask[d] are both set, digit d is treated as unlit for the whole slot.
- Output per cycle:
  - Lit: `dig` enables only bit d, and `seg`=active[d] with polarity applied.
  - Unlit: all `dig` inactive and all `seg` inactive.
- `brightness` and `blink_mask` are sampled every cycle with no buffering.

## Timing
- All outputs are registered. Outputs in cycle t reflect `s`/`d`/`active` as of cycle t-1. Latency is 1 cycle.
- `frame_sync`=1 exactly in the cycle the outputs reflect d=0, s=0. That is once per 4·`SCAN_DIV` cycles.
- An accepted frame is first visible on the output cycle reflecting d=0, s=0 after the next boundary.
- `frame_ready` falls the cycle after an accept and rises the cycle after the boundary that drains `pending`.
- A synchronous `rst` in any cycle, including mid-frame, takes effect at that edge. The next cycle shows:
  - s=0, d=0, `active`=0, pending empty;
  - blink counter 0, `blink_off`=0;
  - `seg` all inactive (7'h7F when active-low), `dig` all inactive (4'hF when active-low);
  - `frame_ready`=1, `frame_sync`=0.
- After reset release, the first `frame_sync` occurs 1 cycle later.

## Test plan
All tests use `SCAN_DIV`=9, `BLINK_FRAMES`=2, active-low polarity.
- Reset: assert `rst` mid-frame for 1 cycle → next cycle `seg`=7'h7F, `dig`=4'hF, `frame_ready`=1. `frame_sync` pulses 1 cycle after release, then every 36 cycles.
- Display, brightness=7:
  - Accept `frame_in`={7'd119,7'd56,7'd63,7'd118}, then wait one boundary.
  - Digit-0 slot: s=0 dark; s=1..8 `dig`=4'b1110, `seg`=7'h09.
  - Digit-3 slot: `dig`=4'b0111, `seg`=7'h08.
- Handshake:
  - Accept frame F1 mid-frame → `frame_ready`=0 next cycle.
  - Hold F2 valid → not accepted until the boundary. After the boundary F1 is displayed and ready=1.
  - F2 is accepted the following cycle.
- Bypass: assert valid exactly on a boundary cycle with pending empty → `frame_ready` stays 1. The new frame is shown from the next frame_sync.
- Brightness sweep: brightness=0 → only s=1 lit per slot. brightness=3 → s=1..4 lit.
- Blink: `blink_mask`=4'b0001 → digit 0 is lit in frames 0–1, dark (`dig`=4'hF, `seg`=7'h7F) in frames 2–3, and lit in frames 4–5. Digits 1–3 are unaffected.
